inv_subbytes_seq: RTL and testbench

Serialized AES InvSubBytes stage for the decryption datapath: the inverse of the forward SubBytes register stage. It applies the FIPS-197 inverse S-box to all 16 bytes of a 128-bit state, LANES bytes per clock, under a start/busy/done handshake. Trading latency for area, it shares LANES inverse S-box lookups instead of 16. It sits between InvShiftRows and AddRoundKey in the iterative decryption round.

---
 rtl/inv_subbytes_seq.sv | 125 ++++++++++++
 tb/tb_inv_subbytes_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_subbytes_seq.sv
// Serialized AES InvSubBytes stage.
//
// Applies the FIPS-197 inverse S-box to the 16 bytes of a 128-bit state. Each enabled cycle
// handles LANES bytes, so a block takes 16/LANES processing cycles. Only LANES lookup
// instances exist. Sits between InvShiftRows and AddRoundKey in the iterative decryption round.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   ena        global clock enable; low freezes all state including outputs
//   start      block request, accepted only when idle and ena is high
//   state_in   input state, byte i = state_in[8i+7:8i], sampled on the accepting edge
//   busy       high while a block is being processed
//   done       one-enabled-cycle pulse; state_out holds the new result
//   state_out  InvSubBytes(state_in), updated only on the completing edge
module inv_subbytes_seq #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         start,
    input  logic [127:0] state_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] state_out
);

    // Guarded so an illegal LANES=0 reports the error below rather than a divide by zero.
    localparam int unsigned N = (LANES == 0) ? 1 : 16 / LANES;
    localparam logic [3:0] LAST = 4'(N - 1);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16))
        begin : g_bad_lanes
            $error("inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Inverse S-box, entry 0x00 in the top byte and entry 0xff in the bottom byte.
    localparam logic [2047:0] INV_SBOX = {
        256'h52096ad53036a538bf40a39e81f3d7fb_7ce339829b2fff87348e4344c4dee9cb,
        256'h547b9432a6c2233dee4c950b42fac34e_082ea16628d924b2765ba2496d8bd125,
        256'h72f8f66486689816d4a45ccc5d65b692_6c704850fdedb9da5e154657a78d9d84,
        256'h90d8ab008cbcd30af7e45805b8b34506_d02c1e8fca3f0f02c1afbd0301138a6b,
        256'h3a9111414f67dcea97f2cfcef0b4e673_96ac7422e7ad3585e2f937e81c75df6e,
        256'h47f11a711d29c5896fb7620eaa18be1b_fc563e4bc6d279209adbc0fe78cd5af4,
        256'h1fdda8338807c731b11210592780ec5f_60517fa919b54a0d2de57a9f93c99cef,
        256'ha0e03b4dae2af5b0c8ebbb3c83539961_172b047eba77d626e169146355210c7d
    };

    // Entry b sits at bit offset 8*(255-b); for an 8-bit b, 255-b is simply ~b.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    typedef enum logic {StIdle, StBusy} state_e;

    state_e         state_q, state_d;
    logic [127:0]   work_q, work_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           done_q, done_d;
    logic [127:0]   out_q, out_d;
    logic [127:0]   sub_work;
    logic [3:0]     lane_idx;

    // Work register with the current chunk of LANES bytes substituted.
    always_comb begin
        sub_work = work_q;
        lane_idx = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_idx = 4'(32'(cnt_q) * LANES + l);
            sub_work[{lane_idx, 3'b000} +: 8] = inv_sbox(work_q[{lane_idx, 3'b000} +: 8]);
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    work_d  = state_in;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                work_d = sub_work;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == LAST) begin
                    out_d   = sub_work;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            work_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else if (ena) begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    assign busy      = (state_q == StBusy);
    assign done      = done_q;
    assign state_out = out_q;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Bench for inv_subbytes_seq: one instance per legal LANES value (1,2,4,8,16), indexed by k
// with LANES = 1 << k. The reference S-boxes are derived from GF(2^8) arithmetic.
module tb_inv_subbytes_seq;

    logic         clk;
    logic         rst;
    logic         ena;
    logic [127:0] state_in;
    logic         start_v [5];
    logic         busy_v  [5];
    logic         done_v  [5];
    logic [127:0] out_v   [5];

    int checks = 0;
    int errors = 0;

    logic [7:0] fwd_m [256];
    logic [7:0] inv_m [256];

    genvar g;
    generate
        for (g = 0; g < 5; g++) begin : g_dut
            inv_subbytes_seq #(.LANES(1 << g)) u_dut (
                .clk      (clk),
                .rst      (rst),
                .ena      (ena),
                .start    (start_v[g]),
                .state_in (state_in),
                .busy     (busy_v[g]),
                .done     (done_v[g]),
                .state_out(out_v[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        logic [7:0] r;
        r = b ^ 8'h63;
        for (int s = 1; s <= 4; s++) r = r ^ ((b << s) | (b >> (8 - s)));
        return r;
    endfunction

    task automatic build_model();
        logic [7:0] y;
        for (int x = 0; x < 256; x++) begin
            y = 8'h00;
            if (x != 0)
                for (int c = 1; c < 256; c++)
                    if (gmul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
            fwd_m[x] = affine(y);
        end
        for (int x = 0; x < 256; x++) inv_m[fwd_m[x]] = 8'(x);
    endtask

    function automatic logic [127:0] fwd_state(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = fwd_m[s[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] inv_state(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_m[s[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Accept one block on instance k, then run until done (optionally with random ena stalls).
    task automatic run_block(input int k, input logic [127:0] data, input bit stall,
                             output logic [127:0] res, output int edges);
        bit           got;
        bit           e;
        logic [1:0]   flags;
        logic [127:0] o;
        @(negedge clk);
        state_in   = data;
        start_v[k] = 1'b1;
        ena        = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        state_in   = rand128();
        check("busy after accept", 128'(busy_v[k]), 128'd1);
        edges = 0;
        got   = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            e     = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            ena   = e;
            flags = {busy_v[k], done_v[k]};
            o     = out_v[k];
            @(negedge clk);
            if (e) edges++;
            else begin
                check("frozen flags", 128'({busy_v[k], done_v[k]}), 128'(flags));
                check("frozen out", out_v[k], o);
            end
            if (done_v[k]) got = 1'b1;
            else check("busy while processing", 128'(busy_v[k]), 128'd1);
        end
        ena = 1'b1;
        res = out_v[k];
        if (!got) check("done timeout", 128'd0, 128'd1);
        else begin
            check("busy low at done", 128'(busy_v[k]), 128'd0);
            @(negedge clk);
            check("done single pulse", 128'(done_v[k]), 128'd0);
            check("out held after done", out_v[k], res);
        end
    endtask

    task automatic wait_done(input int k, input int maxc, output int cyc);
        bit got;
        cyc = 0;
        got = 1'b0;
        ena = 1'b1;
        while (!got && cyc < maxc) begin
            @(negedge clk);
            cyc++;
            if (done_v[k]) got = 1'b1;
        end
        if (!got) check("done timeout", 128'd0, 128'd1);
    endtask

    typedef struct {
        int           k;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    initial begin
        vec_t         vecs [5];
        logic [127:0] res;
        logic [127:0] orig;
        logic [127:0] a;
        logic [127:0] b;
        int           edges;
        int           cyc;
        int           seen;

        vecs[0] = '{2, 128'h16ed7c63_16ed7c63_16ed7c63_16ed7c63,
                       128'hff530100_ff530100_ff530100_ff530100};
        vecs[1] = '{4, 128'h0f0e0d0c_0b0a0908_07060504_03020100,
                       128'hfbd7f381_9ea340bf_38a53630_d56a0952};
        vecs[2] = '{0, {16{8'h63}}, 128'h0};
        vecs[3] = '{3, {16{8'h00}}, {16{8'h52}}};
        vecs[4] = '{1, {16{8'h16}}, {16{8'hff}}};

        build_model();

        rst      = 1'b1;
        ena      = 1'b0;
        state_in = '0;
        for (int k = 0; k < 5; k++) start_v[k] = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("reset busy", 128'(busy_v[k]), 128'd0);
            check("reset done", 128'(done_v[k]), 128'd0);
            check("reset out", out_v[k], 128'd0);
        end
        rst = 1'b0;

        // Known-answer vectors.
        for (int i = 0; i < 5; i++) begin
            run_block(vecs[i].k, vecs[i].din, 1'b0, res, edges);
            check("vector out", res, vecs[i].exp);
            check("vector latency", 128'(edges), 128'(16 >> vecs[i].k));
        end

        // Round trip through the forward S-box model for every LANES.
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 1000; i++) begin
                orig = rand128();
                run_block(k, fwd_state(orig), 1'b0, res, edges);
                check("round trip", res, orig);
                check("round trip latency", 128'(edges), 128'(16 >> k));
            end
        end

        // Random ena stalls, LANES=2.
        for (int i = 0; i < 20; i++) begin
            orig = rand128();
            run_block(1, fwd_state(orig), 1'b1, res, edges);
            check("stall result", res, orig);
            check("stall latency", 128'(edges), 128'd8);
        end

        // Every byte value through LANES=16.
        for (int blk = 0; blk < 16; blk++) begin
            for (int i = 0; i < 16; i++) a[8*i +: 8] = 8'(16 * blk + i);
            run_block(4, a, 1'b0, res, edges);
            check("exhaustive sbox", res, inv_state(a));
            check("exhaustive latency", 128'(edges), 128'd1);
        end

        // start during BUSY with different data is ignored.
        a = rand128();
        b = rand128();
        @(negedge clk);
        state_in   = a;
        start_v[2] = 1'b1;
        ena        = 1'b1;
        @(negedge clk);
        state_in = b;
        repeat (2) @(negedge clk);
        start_v[2] = 1'b0;
        state_in   = '0;
        wait_done(2, 20, cyc);
        check("ignore start result", out_v[2], inv_state(a));
        check("ignore start latency", 128'(cyc + 2), 128'd4);
        repeat (3) @(negedge clk);
        check("ignore start not queued", 128'({busy_v[2], done_v[2]}), 128'd0);

        // start held through done: back-to-back blocks.
        a = rand128();
        b = rand128();
        @(negedge clk);
        state_in   = a;
        start_v[2] = 1'b1;
        ena        = 1'b1;
        @(negedge clk);
        state_in = b;
        wait_done(2, 20, cyc);
        check("b2b first result", out_v[2], inv_state(a));
        check("b2b first latency", 128'(cyc), 128'd4);
        @(negedge clk);
        check("b2b accept", 128'({busy_v[2], done_v[2]}), 128'b10);
        start_v[2] = 1'b0;
        wait_done(2, 20, cyc);
        check("b2b second result", out_v[2], inv_state(b));
        check("b2b done spacing", 128'(cyc + 1), 128'd5);

        // Reset two edges into a block.
        @(negedge clk);
        state_in   = rand128();
        start_v[2] = 1'b1;
        ena        = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        repeat (2) @(negedge clk);
        check("pre-reset busy", 128'(busy_v[2]), 128'd1);
        rst = 1'b1;
        #1;
        check("mid reset busy", 128'(busy_v[2]), 128'd0);
        check("mid reset done", 128'(done_v[2]), 128'd0);
        check("mid reset out", out_v[2], 128'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done_v[2] || busy_v[2]) seen++;
        end
        check("no activity after reset", 128'(seen), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
